// File: rtl/surfers_pkg.sv
// Shared definitions for the surfers game datapath: obstacle word layout,
// obstacle type codes and player pose codes used by generator and checker.
package surfers_pkg;

    localparam int OBS_W         = 16;
    localparam int OBS_TYPE_MSB  = 15;
    localparam int OBS_TYPE_LSB  = 13;
    localparam int OBS_LANE_MSB  = 12;
    localparam int OBS_LANE_LSB  = 11;
    localparam int OBS_DEPTH_MSB = 10;
    localparam int OBS_DEPTH_LSB = 0;
    localparam int DEPTH_W       = OBS_DEPTH_MSB - OBS_DEPTH_LSB + 1;

    typedef enum logic [2:0] {
        OBS_NONE   = 3'b000,
        OBS_JUMP   = 3'b001,
        OBS_DUCK   = 3'b010,
        OBS_MIDDLE = 3'b011,
        OBS_TRAIN  = 3'b100,
        OBS_RAMP   = 3'b101,
        OBS_CAR    = 3'b110
    } obs_type_e;

    typedef enum logic [1:0] {
        POSE_RUN     = 2'b00,
        POSE_JUMP    = 2'b01,
        POSE_DUCK    = 2'b10,
        POSE_RUN_ALT = 2'b11
    } pose_e;

endpackage

// File: rtl/hit_rule.sv
// Per-obstacle-type contact rule: decides whether the latched player state
// collides with an obstacle type, or lands on a train roof / ramp instead.
module hit_rule
    import surfers_pkg::*;
#(
    parameter int TRAIN_HEIGHT = 64
) (
    input  logic [2:0] type_i,
    input  logic [1:0] pose_i,
    input  logic [7:0] height_i,
    output logic       hit_o,
    output logic       roof_o,
    output logic       ramp_o
);

    logic [31:0] height_ext;
    logic        below_roof;

    assign height_ext = {24'd0, height_i};
    assign below_roof = height_ext < $unsigned(TRAIN_HEIGHT);

    always_comb begin
        hit_o  = 1'b0;
        roof_o = 1'b0;
        ramp_o = 1'b0;
        case (type_i)
            OBS_JUMP:   hit_o = (pose_i != POSE_JUMP);
            OBS_DUCK:   hit_o = (pose_i != POSE_DUCK);
            OBS_MIDDLE: hit_o = (pose_i == POSE_RUN) || (pose_i == POSE_RUN_ALT);
            OBS_TRAIN: begin
                hit_o  = below_roof;
                roof_o = !below_roof;
            end
            OBS_RAMP:   ramp_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/collision_checker.sv
// Per-frame collision checker: latches the player state on activate, picks the
// nearest qualifying obstacle in the player's lane and reports the outcome.
module collision_checker
    import surfers_pkg::*;
#(
    parameter int HIT_DEPTH    = 64,
    parameter int TRAIN_HEIGHT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        activate,
    input  logic        obs_valid,
    input  logic        obs_first_row,
    input  logic [15:0] obs,
    input  logic        obs_done,
    input  logic [1:0]  player_lane,
    input  logic [1:0]  player_pose,
    input  logic [7:0]  player_height,
    output logic        result_valid,
    output logic        collision,
    output logic [2:0]  hit_type,
    output logic        on_train,
    output logic        on_ramp,
    output logic        game_over,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_REPORT} state_e;

    localparam logic [DEPTH_W-1:0] HIT_DEPTH_L = DEPTH_W'(HIT_DEPTH);

    state_e       state_q, state_d;
    logic [1:0]   lane_q, lane_d;
    logic [1:0]   pose_q, pose_d;
    logic [7:0]   height_q, height_d;
    logic         matched_q, matched_d;
    logic         collision_q, collision_d;
    logic [2:0]   hit_type_q, hit_type_d;
    logic         on_train_q, on_train_d;
    logic         on_ramp_q, on_ramp_d;
    logic         game_over_q, game_over_d;

    logic [2:0]         obs_type;
    logic [1:0]         obs_lane;
    logic [DEPTH_W-1:0] obs_depth;
    logic               rule_hit, rule_roof, rule_ramp;
    logic               qualify;

    assign obs_type  = obs[OBS_TYPE_MSB:OBS_TYPE_LSB];
    assign obs_lane  = obs[OBS_LANE_MSB:OBS_LANE_LSB];
    assign obs_depth = obs[OBS_DEPTH_MSB:OBS_DEPTH_LSB];

    hit_rule #(.TRAIN_HEIGHT(TRAIN_HEIGHT)) u_hit_rule (
        .type_i   (obs_type),
        .pose_i   (pose_q),
        .height_i (height_q),
        .hit_o    (rule_hit),
        .roof_o   (rule_roof),
        .ramp_o   (rule_ramp)
    );

    // Only the nearest row can touch the player; the first match locks the frame.
    assign qualify = obs_valid && obs_first_row && (obs_lane == lane_q)
                  && (obs_depth <= HIT_DEPTH_L)
                  && (obs_type != OBS_NONE) && (obs_type != OBS_CAR)
                  && !matched_q;

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        pose_d      = pose_q;
        height_d    = height_q;
        matched_d   = matched_q;
        collision_d = collision_q;
        hit_type_d  = hit_type_q;
        on_train_d  = on_train_q;
        on_ramp_d   = on_ramp_q;
        game_over_d = game_over_q;

        if ((state_q != S_REPORT) && activate) begin
            state_d     = S_COLLECT;
            lane_d      = player_lane;
            pose_d      = player_pose;
            height_d    = player_height;
            matched_d   = 1'b0;
            collision_d = 1'b0;
            hit_type_d  = OBS_NONE;
            on_train_d  = 1'b0;
            on_ramp_d   = 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (qualify) begin
                        matched_d   = 1'b1;
                        collision_d = rule_hit;
                        hit_type_d  = rule_hit ? obs_type : OBS_NONE;
                        on_train_d  = rule_roof;
                        on_ramp_d   = rule_ramp;
                    end
                    // game_over must already be visible while result_valid is high.
                    if (obs_done) begin
                        state_d     = S_REPORT;
                        game_over_d = game_over_q | collision_d;
                    end
                end
                S_REPORT: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lane_q      <= '0;
            pose_q      <= '0;
            height_q    <= '0;
            matched_q   <= 1'b0;
            collision_q <= 1'b0;
            hit_type_q  <= '0;
            on_train_q  <= 1'b0;
            on_ramp_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            pose_q      <= pose_d;
            height_q    <= height_d;
            matched_q   <= matched_d;
            collision_q <= collision_d;
            hit_type_q  <= hit_type_d;
            on_train_q  <= on_train_d;
            on_ramp_q   <= on_ramp_d;
            game_over_q <= game_over_d;
        end
    end

    assign result_valid = (state_q == S_REPORT);
    assign busy         = (state_q == S_COLLECT);
    assign collision    = collision_q;
    assign hit_type     = hit_type_q;
    assign on_train     = on_train_q;
    assign on_ramp      = on_ramp_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_collision_checker.sv
// Directed and randomized frames for collision_checker, checked against a
// frame-level reference model that scans the words of each frame.
module tb_collision_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        activate;
    logic        obs_valid;
    logic        obs_first_row;
    logic [15:0] obs;
    logic        obs_done;
    logic [1:0]  player_lane;
    logic [1:0]  player_pose;
    logic [7:0]  player_height;
    logic        result_valid;
    logic        collision;
    logic [2:0]  hit_type;
    logic        on_train;
    logic        on_ramp;
    logic        game_over;
    logic        busy;

    always #5 clk = ~clk;

    collision_checker #(.HIT_DEPTH(64), .TRAIN_HEIGHT(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .activate      (activate),
        .obs_valid     (obs_valid),
        .obs_first_row (obs_first_row),
        .obs           (obs),
        .obs_done      (obs_done),
        .player_lane   (player_lane),
        .player_pose   (player_pose),
        .player_height (player_height),
        .result_valid  (result_valid),
        .collision     (collision),
        .hit_type      (hit_type),
        .on_train      (on_train),
        .on_ramp       (on_ramp),
        .game_over     (game_over),
        .busy          (busy)
    );

    typedef struct {
        logic        v;
        logic        f;
        logic [15:0] w;
    } word_t;

    word_t       frame_q[$];
    logic [1:0]  m_lane;
    logic [1:0]  m_pose;
    logic [7:0]  m_height;
    logic        m_go;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          rv_seen = 0;
    int          rv_exp = 0;

    // Counts result strobes; sampled value is the one from the previous cycle.
    always @(posedge clk) if (result_valid === 1'b1) rv_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Nearest qualifying word decides the frame; everything after it is ignored.
    function automatic void model(output logic c, output logic [2:0] ht,
                                  output logic tr, output logic rp);
        c = 1'b0; ht = 3'd0; tr = 1'b0; rp = 1'b0;
        foreach (frame_q[i]) begin
            logic [2:0]  t;
            logic [1:0]  ln;
            int unsigned d;
            t  = frame_q[i].w[15:13];
            ln = frame_q[i].w[12:11];
            d  = frame_q[i].w[10:0];
            if (frame_q[i].v && frame_q[i].f && ln == m_lane && d <= 64 && t != 3'd0 && t != 3'd6) begin
                case (t)
                    3'd1: c = (m_pose != 2'd1);
                    3'd2: c = (m_pose != 2'd2);
                    3'd3: c = (m_pose == 2'd0) || (m_pose == 2'd3);
                    3'd4: begin c = (m_height < 8'd64); tr = !c; end
                    3'd5: rp = 1'b1;
                    default: ;
                endcase
                if (c) ht = t;
                return;
            end
        end
    endfunction

    task automatic start_frame(input logic [1:0] ln, input logic [1:0] ps, input logic [7:0] ht);
        activate = 1'b1;
        player_lane = ln; player_pose = ps; player_height = ht;
        m_lane = ln; m_pose = ps; m_height = ht;
        frame_q.delete();
        @(negedge clk);
        activate = 1'b0;
        player_lane = 2'($urandom); player_pose = 2'($urandom); player_height = 8'($urandom);
        check("busy_after_activate", busy, 1);
        check("rv_after_activate", result_valid, 0);
    endtask

    task automatic send(input logic v, input logic f, input logic [2:0] t,
                        input logic [1:0] ln, input logic [10:0] d);
        word_t wd;
        obs_valid = v; obs_first_row = f; obs = {t, ln, d};
        wd.v = v; wd.f = f; wd.w = {t, ln, d};
        frame_q.push_back(wd);
        @(negedge clk);
        obs_valid = 1'b0; obs_first_row = 1'($urandom); obs = 16'($urandom);
        player_pose = 2'($urandom); player_height = 8'($urandom);
    endtask

    task automatic finish_frame(input string tag);
        logic ec; logic [2:0] eh; logic et, er;
        model(ec, eh, et, er);
        if (ec) m_go = 1'b1;
        obs_done = 1'b1;
        @(negedge clk);
        obs_done = 1'b0;
        rv_exp++;
        check({tag, "_rv"}, result_valid, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_coll"}, collision, ec);
        check({tag, "_type"}, hit_type, eh);
        check({tag, "_train"}, on_train, et);
        check({tag, "_ramp"}, on_ramp, er);
        check({tag, "_go"}, game_over, m_go);
        obs_done = 1'b1;
        @(negedge clk);
        obs_done = 1'b0;
        check({tag, "_rv_drop"}, result_valid, 0);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_coll_hold"}, collision, ec);
        check({tag, "_type_hold"}, hit_type, eh);
        check({tag, "_rv_count"}, rv_seen, rv_exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        m_go = 1'b0;
    endtask

    initial begin
        rst = 1'b1; activate = 1'b0; obs_valid = 1'b0; obs_first_row = 1'b0;
        obs = '0; obs_done = 1'b0; player_lane = '0; player_pose = '0; player_height = '0;
        m_go = 1'b0; m_lane = '0; m_pose = '0; m_height = '0;
        @(negedge clk);
        do_reset();
        check("rst_rv", result_valid, 0);
        check("rst_coll", collision, 0);
        check("rst_type", hit_type, 0);
        check("rst_train", on_train, 0);
        check("rst_ramp", on_ramp, 0);
        check("rst_go", game_over, 0);
        check("rst_busy", busy, 0);

        // obs_done while idle must not produce a result.
        obs_done = 1'b1; obs_valid = 1'b1;
        @(negedge clk);
        obs_done = 1'b0; obs_valid = 1'b0;
        @(negedge clk);
        check("idle_done_busy", busy, 0);
        check("idle_done_rv", rv_seen, rv_exp);

        start_frame(2'd1, 2'd0, 8'd0);
        send(1, 1, 3'd1, 2'd1, 11'd40);
        finish_frame("jump_run");
        check("jump_run_hit_const", hit_type, 3'b001);
        check("jump_run_go_const", game_over, 1);

        start_frame(2'd1, 2'd1, 8'd0);
        send(1, 1, 3'd1, 2'd1, 11'd40);
        finish_frame("jump_jump");
        check("jump_jump_coll_const", collision, 0);

        start_frame(2'd0, 2'd0, 8'd64);
        send(1, 1, 3'd4, 2'd0, 11'd60);
        finish_frame("train_h64");
        check("train_h64_roof_const", on_train, 1);
        start_frame(2'd0, 2'd0, 8'd63);
        send(1, 1, 3'd4, 2'd0, 11'd60);
        finish_frame("train_h63");
        check("train_h63_type_const", hit_type, 3'b100);

        start_frame(2'd2, 2'd2, 8'd10);
        send(1, 1, 3'd2, 2'd2, 11'd65);
        send(1, 1, 3'd1, 2'd2, 11'd30);
        finish_frame("depth_edge");
        check("depth_edge_type_const", hit_type, 3'b001);

        start_frame(2'd1, 2'd0, 8'd0);
        send(1, 0, 3'd1, 2'd1, 11'd20);
        send(0, 1, 3'd1, 2'd1, 11'd20);
        send(1, 1, 3'd6, 2'd1, 11'd20);
        send(1, 1, 3'd5, 2'd1, 11'd64);
        finish_frame("ignored_words");

        // Restart mid-frame: the aborted frame's hit must vanish.
        start_frame(2'd0, 2'd0, 8'd0);
        send(1, 1, 3'd3, 2'd0, 11'd5);
        start_frame(2'd0, 2'd1, 8'd0);
        check("restart_coll_clear", collision, 0);
        send(1, 1, 3'd5, 2'd0, 11'd7);
        finish_frame("restart");

        // activate and obs_done together: restart wins, no report.
        start_frame(2'd2, 2'd0, 8'd0);
        send(1, 1, 3'd1, 2'd2, 11'd1);
        obs_done = 1'b1;
        start_frame(2'd2, 2'd1, 8'd0);
        obs_done = 1'b0;
        send(1, 1, 3'd1, 2'd2, 11'd1);
        finish_frame("act_done");

        // Reset mid-frame discards the frame and clears game_over.
        start_frame(2'd1, 2'd0, 8'd0);
        send(1, 1, 3'd1, 2'd1, 11'd3);
        do_reset();
        check("midrst_busy", busy, 0);
        check("midrst_go", game_over, 0);
        check("midrst_coll", collision, 0);
        @(negedge clk);
        check("midrst_rv", rv_seen, rv_exp);
        start_frame(2'd1, 2'd2, 8'd0);
        send(1, 1, 3'd3, 2'd1, 11'd3);
        finish_frame("after_rst");

        for (int fr = 0; fr < 60; fr++) begin
            logic [1:0] pl;
            int nw;
            pl = 2'($urandom_range(0, 2));
            start_frame(pl, 2'($urandom), 8'($urandom_range(50, 80)));
            nw = $urandom_range(1, 6);
            for (int k = 0; k < nw; k++) begin
                send(($urandom % 4) != 0, ($urandom % 3) != 0, 3'($urandom),
                     ($urandom % 2) ? pl : 2'($urandom_range(0, 2)),
                     11'($urandom_range(0, 80)));
            end
            if (fr % 7 == 3) do_reset();
            else finish_frame("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/collision_checker.md
COLLISION_CHECKER -- requirements
Module: collision_checker

Interface
REQ-001 SHALL have parameter HIT_DEPTH, default 64, meaning the largest obstacle end-depth (units) that can contact the player.
REQ-002 SHALL have parameter TRAIN_HEIGHT, default 64, meaning the train roof height (units).
REQ-003 SHALL have the following ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- activate  in  1  one-cycle frame start, the same pulse that drives the obstacle generator.
- obs_valid  in  1  obstacle word valid; no backpressure.
- obs_first_row  in  1  word belongs to the nearest occupied row.
- obs  in  16  obstacle word: [15:13] type, [12:11] lane, [10:0] end depth (unsigned).
- obs_done  in  1  generator finished the frame.
- player_lane  in  2  0..2.
- player_pose  in  2  00 run, 01 jump, 10 duck, 11 treated as run.
- player_height  in  8  feet height above ground.
- result_valid  out  1  one-cycle result strobe.
- collision  out  1  frame result: hit.
- hit_type  out  3  type of the obstacle hit, else 000.
- on_train  out  1  player supported by a train roof this frame.
- on_ramp  out  1  player on a ramp this frame.
- game_over  out  1  sticky collision flag.
- busy  out  1  high in COLLECT.

Function
REQ-004 SHALL implement FSM IDLE -> COLLECT on activate; COLLECT -> REPORT on obs_done; REPORT -> IDLE after one cycle.
REQ-005 SHALL, on activate, latch player_lane, player_pose and player_height into registers and clear the per-frame flags (matched, collision, hit_type, on_train, on_ramp).
REQ-006 SHALL, in COLLECT, qualify a word when all of the following hold: obs_valid=1, obs_first_row=1, obs[12:11] equals the latched lane, obs[10:0] <= HIT_DEPTH, type is not 000 or 110, and matched=0.
REQ-007 SHALL, on the first qualifying word only, set matched=1; all later words in the frame are ignored (the nearest obstacle wins).
REQ-008 SHALL evaluate the qualifying word by type:
- 001 hits unless pose = jump.
- 010 hits unless pose = duck.
- 011 hits when pose is run or 11.
- 100 hits when latched height < TRAIN_HEIGHT; otherwise sets on_train.
- 101 never hits and sets on_ramp.
REQ-009 SHALL, on a hit, set collision=1 and hit_type to the obstacle type.
REQ-010 SHALL compare depth as an 11-bit unsigned value; HIT_DEPTH is zero-extended to 11 bits.
REQ-011 SHALL hold result_valid high for exactly the REPORT cycle, which is the cycle after obs_done is sampled.
REQ-012 SHALL keep collision, hit_type, on_train and on_ramp stable from REPORT until the next activate.
REQ-013 SHALL set game_over in the cycle result_valid is asserted with collision=1; game_over clears only on rst.
REQ-014 SHALL restart when activate arrives in COLLECT: abort the frame, emit no result_valid, re-latch inputs and stay in COLLECT.
REQ-015 SHALL have activate take priority when activate and obs_done arrive in the same cycle.
REQ-016 SHALL ignore obs_valid and obs_done while in IDLE or REPORT.
REQ-017 SHALL ignore activate while in REPORT; the generator cannot issue it there.
REQ-018 SHALL ignore player inputs except on the activate cycle.

Reset
REQ-019 SHALL, on rst, set the state to IDLE and all outputs to 0, including game_over, busy and hit_type.
REQ-020 SHALL have rst asserted mid-frame discard the frame, with no result_valid pulse.

Structure
REQ-021 SHALL take obstacle type codes (000 none, 001 jump barrier, 010 duck barrier, 011 middle barrier, 100 train, 101 ramp, 110 moving car), pose codes and the obstacle word field positions from a shared package, surfers_pkg, which is also used by the generator.
REQ-022 SHALL contain the FSM state enum locally.
REQ-023 SHALL place the per-type hit rule in a combinational sub-module, hit_rule, with inputs type, pose and height and outputs hit, roof and ramp.

Verification
REQ-024 SHALL cover: lane 1, pose run, word type 001, lane 1, depth 40, first_row -> result_valid 1 cycle after done, collision=1, hit_type=001, game_over=1.
REQ-025 SHALL cover: same word with pose jump -> collision=0, hit_type=000, game_over unchanged.
REQ-026 SHALL cover: type 100, depth 60, latched height 64 -> collision=0, on_train=1; repeat with height 63 -> collision=1, hit_type=100.
REQ-027 SHALL cover: type 010 at depth 65, then type 001 at depth 30, in player lane with pose duck -> depth 65 ignored (> HIT_DEPTH), depth 30 word hits, hit_type=001.
REQ-028 SHALL cover: first_row=0 word type 001, depth 20, pose run -> no collision; also a word with obs_valid=0 -> ignored.
REQ-029 SHALL cover: activate mid-COLLECT, and separately rst mid-COLLECT -> no result_valid; after re-activate and done, a single result_valid reflecting only new-frame words; player inputs changed after activate have no effect.
